// File: rtl/vector_cache_pkg.sv
// Shared sizing constants for the vector cache miss-handling blocks.
package vector_cache_pkg;

  localparam int unsigned MSHR_ENTRY_NUM = 16;
  localparam int unsigned MSHR_IDX_WIDTH = 4;
  localparam int unsigned MSHR_REL_NUM   = 2;
  localparam int unsigned MSHR_LOW_WM    = 2;

endpackage

// File: rtl/vec_cache_free_pick2.sv
// Combinational finder for the two lowest set bits of a vector.
// Returns one-hot and binary index for each pick plus per-pick valids.
module vec_cache_free_pick2 #(
  parameter int unsigned N  = 16,
  parameter int unsigned IW = 4
) (
  input  logic [N-1:0]  vec,
  output logic [N-1:0]  oh_0,
  output logic [N-1:0]  oh_1,
  output logic [IW-1:0] idx_0,
  output logic [IW-1:0] idx_1,
  output logic          vld_0,
  output logic          vld_1
);

  logic [N-1:0] rem;

  // Isolate lowest set bit, strip it, isolate the next one, then encode both.
  always_comb begin
    oh_0  = vec & (~vec + N'(1));
    rem   = vec & ~oh_0;
    oh_1  = rem & (~rem + N'(1));
    vld_0 = |vec;
    vld_1 = |rem;
    idx_0 = '0;
    idx_1 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (oh_0[i]) idx_0 = IW'(i);
      if (oh_1[i]) idx_1 = IW'(i);
    end
  end

endmodule

// File: rtl/vec_cache_mshr_alloc_ctrl.sv
// MSHR/ROB entry allocator: free bitmap plus free count, two zero-latency
// allocation slots and REL_NUM release ports.
// Optional feature macro: VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN enables the sticky
// illegal-release flag; otherwise err_dbl_free is tied low.
module vec_cache_mshr_alloc_ctrl
  import vector_cache_pkg::*;
#(
  parameter int unsigned ENTRY_NUM       = MSHR_ENTRY_NUM,
  parameter int unsigned ENTRY_IDX_WIDTH = MSHR_IDX_WIDTH,
  parameter int unsigned REL_NUM         = MSHR_REL_NUM,
  parameter int unsigned LOW_WM          = MSHR_LOW_WM
) (
  input  logic                               clk,
  input  logic                               rst,
  output logic                               alloc_vld_0,
  output logic [ENTRY_IDX_WIDTH-1:0]         alloc_idx_0,
  input  logic                               alloc_rdy_0,
  output logic                               alloc_vld_1,
  output logic [ENTRY_IDX_WIDTH-1:0]         alloc_idx_1,
  input  logic                               alloc_rdy_1,
  input  logic [REL_NUM-1:0]                 rel_vld,
  input  logic [REL_NUM*ENTRY_IDX_WIDTH-1:0] rel_idx,
  output logic [ENTRY_IDX_WIDTH:0]           free_cnt,
  output logic                               alloc_low,
  output logic                               err_dbl_free
);

  localparam int unsigned IW = ENTRY_IDX_WIDTH;
  localparam int unsigned CW = ENTRY_IDX_WIDTH + 1;

  logic [ENTRY_NUM-1:0] free_map;
  logic [ENTRY_NUM-1:0] free_map_nxt;
  logic [CW-1:0]        free_cnt_nxt;

  logic [ENTRY_NUM-1:0] pk_oh_0;
  logic [ENTRY_NUM-1:0] pk_oh_1;
  logic [IW-1:0]        pk_idx_0;
  logic [IW-1:0]        pk_idx_1;
  logic                 pk_vld_0;
  logic                 pk_vld_1;

  logic                 take_0;
  logic                 take_1;
  logic [ENTRY_NUM-1:0] set_mask;
  logic [ENTRY_NUM-1:0] set_new;
  logic [ENTRY_NUM-1:0] clr_mask;
  logic [CW-1:0]        n_rel;
  logic [CW-1:0]        n_take;
`ifdef VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN
  logic                 rel_bad;
  logic                 err_q;
`endif

  vec_cache_free_pick2 #(
    .N  (ENTRY_NUM),
    .IW (IW)
  ) u_pick (
    .vec   (free_map),
    .oh_0  (pk_oh_0),
    .oh_1  (pk_oh_1),
    .idx_0 (pk_idx_0),
    .idx_1 (pk_idx_1),
    .vld_0 (pk_vld_0),
    .vld_1 (pk_vld_1)
  );

  // Zero-latency offers from current state; index forced to 0 when not offered.
  always_comb begin
    alloc_vld_0 = (free_cnt != '0) && pk_vld_0;
    alloc_vld_1 = (free_cnt >= CW'(2)) && pk_vld_1;
    alloc_idx_0 = alloc_vld_0 ? pk_idx_0 : '0;
    alloc_idx_1 = alloc_vld_1 ? pk_idx_1 : '0;
    alloc_low   = 32'(free_cnt) <= 32'(LOW_WM);
  end

  // Release decode: only legal ports contribute a bit to the set mask.
  always_comb begin
    logic [IW-1:0] r_idx;
    logic          legal;
    set_mask = '0;
    r_idx    = '0;
    legal    = 1'b0;
`ifdef VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN
    rel_bad  = 1'b0;
`endif
    for (int unsigned p = 0; p < REL_NUM; p++) begin
      r_idx = rel_idx[p*IW +: IW];
      legal = rel_vld[p] && (32'(r_idx) < 32'(ENTRY_NUM));
`ifdef VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN
      // Already free, or a repeat of a lower-numbered port this cycle.
      if (legal && free_map[r_idx]) legal = 1'b0;
      for (int unsigned q = 0; q < p; q++) begin
        if (rel_vld[q] && (rel_idx[q*IW +: IW] == r_idx)) legal = 1'b0;
      end
      if (rel_vld[p] && !legal) rel_bad = 1'b1;
`endif
      if (legal) set_mask[r_idx] = 1'b1;
    end
  end

  // Next bitmap and count; only bits that were actually clear count as releases,
  // so a redundant release can never inflate free_cnt.
  always_comb begin
    take_0   = alloc_vld_0 && alloc_rdy_0;
    take_1   = alloc_vld_1 && alloc_rdy_1;
    clr_mask = (take_0 ? pk_oh_0 : '0) | (take_1 ? pk_oh_1 : '0);
    set_new  = set_mask & ~free_map;
    n_rel    = '0;
    for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
      n_rel = n_rel + CW'(set_new[i]);
    end
    n_take       = CW'(take_0) + CW'(take_1);
    free_map_nxt = (free_map & ~clr_mask) | set_new;
    free_cnt_nxt = free_cnt + n_rel - n_take;
  end

  // Allocation state registers; reset wins over any same-cycle traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_map <= '1;
      free_cnt <= CW'(ENTRY_NUM);
    end else begin
      free_map <= free_map_nxt;
      free_cnt <= free_cnt_nxt;
    end
  end

`ifdef VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN
  // Sticky illegal-release flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (rel_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err_dbl_free = err_q;
`else
  assign err_dbl_free = 1'b0;
`endif

endmodule

// File: doc/vec_cache_mshr_alloc_ctrl.md
VEC_CACHE_MSHR_ALLOC_CTRL -- requirements
Module: vec_cache_mshr_alloc_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_NUM, default 16, meaning number of MSHR/ROB entries managed.
REQ-002 SHALL have parameter ENTRY_IDX_WIDTH, default 4, meaning entry index width, $clog2(ENTRY_NUM).
REQ-003 SHALL have parameter REL_NUM, default 2, meaning number of independent release ports.
REQ-004 SHALL have parameter LOW_WM, default 2, meaning low-watermark threshold on the free count.
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  input  1  clock; rst  input  1  reset.
REQ-006 SHALL have alloc_vld_0  output  1  slot-0 entry offered.
REQ-007 SHALL have alloc_idx_0  output  ENTRY_IDX_WIDTH  slot-0 entry index.
REQ-008 SHALL have alloc_rdy_0  input  1  slot-0 entry consumed.
REQ-009 SHALL have alloc_vld_1, alloc_idx_1 and alloc_rdy_1, with the same widths and meanings, for slot 1.
REQ-010 SHALL have rel_vld  input  REL_NUM  per-port entry release.
REQ-011 SHALL have rel_idx  input  REL_NUM x ENTRY_IDX_WIDTH  released index, per port.
REQ-012 SHALL have free_cnt  output  ENTRY_IDX_WIDTH+1  number of free entries.
REQ-013 SHALL have alloc_low  output  1  free_cnt <= LOW_WM.
REQ-014 SHALL have err_dbl_free  output  1  sticky illegal-release flag.

Function
REQ-015 SHALL hold a free bitmap (bit=1 free) and a free_cnt register; both are the only allocation state.
REQ-016 SHALL drive alloc_idx_0 as the lowest-numbered free entry and alloc_idx_1 as the second-lowest, combinationally from current state (zero-latency offer).
REQ-017 SHALL assert alloc_vld_0 iff free_cnt >= 1 and alloc_vld_1 iff free_cnt >= 2; idx is don't-care when vld=0 but SHALL be driven 0.
REQ-018 SHALL treat a slot as allocated on the cycle vld&&rdy; the bit clears and free_cnt decrements on the next edge.
REQ-019 SHALL accept alloc_rdy_1 without alloc_rdy_0 (slot 1 consumed alone; slot-0 entry stays free); rdy with vld=0 SHALL be ignored.
REQ-020 SHALL set the bitmap bit of rel_idx on each rel_vld port at the next edge; a released entry SHALL NOT be offered in the same cycle as its release.
REQ-021 SHALL update free_cnt as free_cnt + releases accepted - allocations taken per cycle; up to 2 allocations and REL_NUM releases SHALL occur simultaneously.
REQ-022 SHALL treat as illegal: release of an already-free entry, release of the same idx on two ports in one cycle, and release of an idx >= ENTRY_NUM; an illegal release SHALL NOT change state.
REQ-023 SHALL drive alloc_low combinationally from free_cnt.
REQ-024 SHALL never let free_cnt exceed ENTRY_NUM or go below 0.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, set all bitmap bits to 1, free_cnt=ENTRY_NUM and err_dbl_free=0; outputs then show alloc_vld_0=1, alloc_idx_0=0, alloc_vld_1=1, alloc_idx_1=1 and alloc_low=0.
REQ-026 SHALL give reset priority over any same-cycle alloc or release; in-flight entries are discarded.

Configuration
REQ-027 SHALL, with VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN defined, set err_dbl_free sticky (cleared only by reset) on any REQ-022 illegal release.
REQ-028 SHALL, without VEC_CACHE_MSHR_ALLOC_ERR_CHK_EN, tie err_dbl_free to 0 and omit the check logic; the REQ-022 no-state-change rule still holds for an out-of-range idx only.

Structure
REQ-029 SHALL take MSHR_ENTRY_NUM and MSHR_IDX_WIDTH from vector_cache_pkg as the parameter defaults.
REQ-030 SHALL instantiate sub-module vec_cache_free_pick2, a combinational lowest-two-set-bits finder returning two one-hot/index pairs and two valids.

Verification
REQ-031 SHALL verify reset-then-take: after reset, rdy_0=rdy_1=1 for one cycle -> next cycle idx_0=2, idx_1=3, free_cnt=14.
REQ-032 SHALL verify the slot-1-only path: after reset, rdy_1=1 only -> next cycle idx_0=0, idx_1=2, free_cnt=15.
REQ-033 SHALL verify drain to empty: allocate all 16 -> alloc_vld_0=0, alloc_vld_1=0, free_cnt=0, alloc_low=1; then release idx 7 -> next cycle vld_0=1, idx_0=7, vld_1=0.
REQ-034 SHALL verify simultaneous events: free_cnt=1 (entry 5), take it while releasing 3 and 9 -> next cycle free_cnt=2, idx_0=3, idx_1=9.
REQ-035 SHALL verify the double free: release an already-free idx 4 -> free_cnt unchanged, and err_dbl_free=1 only with ERR_CHK_EN defined.
REQ-036 SHALL verify reset mid-operation: 10 entries outstanding, assert rst with concurrent releases -> free_cnt=16 and err_dbl_free=0.
